// File: rtl/threebit_downcounter.sv
// ---------------------------------------------------------------------------
// threebit_downcounter
//   Loadable down-counter with a small IDLE/RUN/DONE controller. A loaded
//   value is counted down one step per accepted decrement while in RUN.
//   Reaching zero either stops the counter (DONE) or reloads it from the
//   value last loaded (AUTO_RELOAD). Either way a one-cycle terminal-count
//   pulse is produced. The count saturates at zero, and a decrement attempted
//   in DONE raises a sticky underflow flag that only a load or reset clears.
//
// Parameters
//   WIDTH        counter width in bits (2..16)
//   AUTO_RELOAD  1 = reload and keep running at terminal count, 0 = stop
//
// Ports
//   clk            clock, all state changes on rising edge
//   rst            asynchronous active-high reset
//   ld             load data_in into counter and reload register
//   start          leave IDLE and begin counting
//   stop           abort counting, back to IDLE holding the count
//   dec            decrement request (acts in RUN; flags underflow in DONE)
//   data_in        load value
//   data_out       current count (registered)
//   zero           high when data_out == 0 (combinational)
//   tc             registered terminal-count pulse, one cycle wide
//   busy           high while in RUN
//   err_underflow  sticky underflow flag
// ---------------------------------------------------------------------------
module threebit_downcounter #(
  parameter int WIDTH       = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             start,
  input  logic             stop,
  input  logic             dec,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             tc,
  output logic             busy,
  output logic             err_underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_next;
  logic             tc_q;
  logic             tc_next;
  logic             err_q;
  logic             err_next;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. ld and stop override everything; start only has a
  // meaning in IDLE, so the start-over-dec priority is only visible there.
  // A start with a zero count skips RUN entirely so no tc can be produced.
  always_comb begin
    state_next = state;
    if (ld) begin
      state_next = IDLE;
    end else if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = (count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (dec) begin
            if (count == WIDTH'(1)) begin
              state_next = AUTO_RELOAD ? RUN : DONE;
            end else if (count == '0) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Datapath next values: count, reload register, tc pulse and sticky error.
  // A count of zero in RUN is not reachable through normal operation, but it
  // is still saturated rather than wrapped.
  always_comb begin
    count_next  = count;
    reload_next = reload;
    tc_next     = 1'b0;
    err_next    = err_q;
    if (ld) begin
      count_next  = data_in;
      reload_next = data_in;
      err_next    = 1'b0;
    end else if (!stop) begin
      if (state == RUN && dec) begin
        if (count > WIDTH'(1)) begin
          count_next = count - WIDTH'(1);
        end else if (count == WIDTH'(1)) begin
          count_next = AUTO_RELOAD ? reload : '0;
          tc_next    = 1'b1;
        end
      end else if (state == DONE && dec) begin
        err_next = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      count  <= count_next;
      reload <= reload_next;
      tc_q   <= tc_next;
      err_q  <= err_next;
    end
  end

  // Output decode; busy comes from the state alone
  always_comb begin
    data_out      = count;
    zero          = (count == '0);
    tc            = tc_q;
    busy          = (state == RUN);
    err_underflow = err_q;
  end

endmodule

// File: tb/tb_threebit_downcounter.sv
// ---------------------------------------------------------------------------
// tb_threebit_downcounter
//   Table-driven bench for threebit_downcounter. Two instances share inputs:
//   dut0 stops at terminal count, dut1 auto-reloads. Each vector names the
//   instance it checks; every sequence begins with a load so the unchecked
//   instance is always brought back to a known state. Expected outputs are
//   queued when a vector is driven and popped when the cycle has completed.
// ---------------------------------------------------------------------------
module tb_threebit_downcounter;

  localparam int W = 3;

  typedef struct {
    string      name;
    bit         sel;
    bit         ld;
    bit         start;
    bit         stop;
    bit         dec;
    logic [2:0] din;
    logic [6:0] exp;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         ld;
  logic         start;
  logic         stop;
  logic         dec;
  logic [W-1:0] data_in;

  logic [W-1:0] q0, q1;
  logic         zero0, zero1, tc0, tc1, busy0, busy1, err0, err1;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  threebit_downcounter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ld(ld), .start(start), .stop(stop), .dec(dec),
    .data_in(data_in), .data_out(q0), .zero(zero0), .tc(tc0), .busy(busy0),
    .err_underflow(err0)
  );

  threebit_downcounter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ld(ld), .start(start), .stop(stop), .dec(dec),
    .data_in(data_in), .data_out(q1), .zero(zero1), .tc(tc1), .busy(busy1),
    .err_underflow(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected output packing: {data_out, zero, tc, busy, err_underflow}
  function automatic vec_t mk(string n, bit sel, bit l, bit s, bit p, bit d,
                              logic [2:0] din, logic [2:0] q, bit t, bit b,
                              bit e);
    vec_t v;
    v.name  = n;
    v.sel   = sel;
    v.ld    = l;
    v.start = s;
    v.stop  = p;
    v.dec   = d;
    v.din   = din;
    v.exp   = {q, (q == 3'd0), t, b, e};
    return v;
  endfunction

  function automatic logic [6:0] observed(bit sel);
    if (sel) return {q1, zero1, tc1, busy1, err1};
    return {q0, zero0, tc0, busy0, err0};
  endfunction

  task automatic compare(string n, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got q=%0d z=%0b tc=%0b busy=%0b err=%0b, want q=%0d z=%0b tc=%0b busy=%0b err=%0b",
               n, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkOutput();
    vec_t v;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, want a pending entry");
      return;
    end
    v = sb.pop_front();
    compare(v.name, observed(v.sel), v.exp);
  endtask

  // Drive one vector just after a rising edge, then check after the next one
  task automatic applyStimulus(vec_t v);
    ld      = v.ld;
    start   = v.start;
    stop    = v.stop;
    dec     = v.dec;
    data_in = v.din;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst     = 1'b1;
    ld      = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    dec     = 1'b0;
    data_in = '0;

    //            name         sel ld st sp dc din  q  tc b  e
    tbl.push_back(mk("ld3",      0, 1, 0, 0, 0, 3'd3, 3'd3, 0, 0, 0));
    tbl.push_back(mk("start3",   0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 1, 0));
    tbl.push_back(mk("dec3to2",  0, 0, 0, 0, 1, 3'd0, 3'd2, 0, 1, 0));
    tbl.push_back(mk("dec2to1",  0, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    tbl.push_back(mk("tc_done",  0, 0, 0, 0, 1, 3'd0, 3'd0, 1, 0, 0));
    tbl.push_back(mk("underflow",0, 0, 0, 0, 1, 3'd0, 3'd0, 0, 0, 1));
    tbl.push_back(mk("sticky",   0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 1));
    tbl.push_back(mk("ld5_clr",  0, 1, 0, 0, 0, 3'd5, 3'd5, 0, 0, 0));
    tbl.push_back(mk("ld7",      0, 1, 0, 0, 0, 3'd7, 3'd7, 0, 0, 0));
    tbl.push_back(mk("start7",   0, 0, 1, 0, 0, 3'd0, 3'd7, 0, 1, 0));
    tbl.push_back(mk("dec7to6",  0, 0, 0, 0, 1, 3'd0, 3'd6, 0, 1, 0));
    tbl.push_back(mk("dec6to5",  0, 0, 0, 0, 1, 3'd0, 3'd5, 0, 1, 0));
    tbl.push_back(mk("stop_dec", 0, 0, 0, 1, 1, 3'd0, 3'd5, 0, 0, 0));
    tbl.push_back(mk("resume5",  0, 0, 1, 0, 0, 3'd0, 3'd5, 0, 1, 0));
    tbl.push_back(mk("dec5to4",  0, 0, 0, 0, 1, 3'd0, 3'd4, 0, 1, 0));
    tbl.push_back(mk("ld0",      0, 1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("start0",   0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("done0_idl",0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0));
    tbl.push_back(mk("ld2",      0, 1, 0, 0, 0, 3'd2, 3'd2, 0, 0, 0));
    tbl.push_back(mk("start2",   0, 0, 1, 0, 0, 3'd0, 3'd2, 0, 1, 0));
    tbl.push_back(mk("dec2to1b", 0, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    tbl.push_back(mk("ld_beats", 0, 1, 0, 1, 1, 3'd6, 3'd6, 0, 0, 0));
    tbl.push_back(mk("ar_ld2",   1, 1, 0, 0, 0, 3'd2, 3'd2, 0, 0, 0));
    tbl.push_back(mk("ar_start", 1, 0, 1, 0, 0, 3'd0, 3'd2, 0, 1, 0));
    tbl.push_back(mk("ar_dec1",  1, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    tbl.push_back(mk("ar_dec2",  1, 0, 0, 0, 1, 3'd0, 3'd2, 1, 1, 0));
    tbl.push_back(mk("ar_dec3",  1, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    tbl.push_back(mk("ar_dec4",  1, 0, 0, 0, 1, 3'd0, 3'd2, 1, 1, 0));
    tbl.push_back(mk("ar_dec5",  1, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    tbl.push_back(mk("ar_dec6",  1, 0, 0, 0, 1, 3'd0, 3'd2, 1, 1, 0));
    tbl.push_back(mk("ar_stop",  1, 0, 0, 1, 0, 3'd0, 3'd2, 0, 0, 0));

    // Reset state straight from the asynchronous reset, before any edge
    #1;
    compare("reset_dut0", observed(1'b0), 7'b000_1_0_0_0);
    compare("reset_dut1", observed(1'b1), 7'b000_1_0_0_0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Asynchronous reset in the middle of RUN, one step before terminal
    // count with dec still held: outputs clear before the next edge and no
    // tc pulse follows.
    applyStimulus(mk("rst_ld2",    0, 1, 0, 0, 0, 3'd2, 3'd2, 0, 0, 0));
    applyStimulus(mk("rst_start",  0, 0, 1, 0, 0, 3'd0, 3'd2, 0, 1, 0));
    applyStimulus(mk("rst_dec",    0, 0, 0, 0, 1, 3'd0, 3'd1, 0, 1, 0));
    #2 rst = 1'b1;
    #1;
    compare("rst_async", observed(1'b0), 7'b000_1_0_0_0);
    #2 rst = 1'b0;
    applyStimulus(mk("rst_no_tc",  0, 0, 0, 0, 1, 3'd0, 3'd0, 0, 0, 0));
    applyStimulus(mk("rst_start0", 0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/threebit_downcounter.md
THREEBIT_DOWNCOUNTER -- requirements
Module: threebit_downcounter

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits, legal range 2..16.
REQ-002 Parameter AUTO_RELOAD, default 0: 1 = reload and keep running at terminal count; 0 = stop at terminal count.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ld  input  1  load data_in into counter and reload register.
REQ-006 start  input  1  begin counting from IDLE.
REQ-007 stop  input  1  abort counting, return to IDLE holding current count.
REQ-008 dec  input  1  decrement request, effective only in RUN.
REQ-009 data_in  input  WIDTH  load value.
REQ-010 data_out  output  WIDTH  current count, registered.
REQ-011 zero  output  1  combinational, high when data_out == 0.
REQ-012 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-013 busy  output  1  high while state == RUN.
REQ-014 err_underflow  output  1  sticky underflow error flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE; busy SHALL be decoded from state only.
REQ-016 Priority per cycle, all states: ld > stop > start > dec.
REQ-017 ld, any state: next cycle data_out = data_in, reload register = data_in, state = IDLE, err_underflow = 0, tc = 0.
REQ-018 IDLE: start with data_out != 0 -> RUN; start with data_out == 0 -> DONE, no tc; dec ignored, no error.
REQ-019 RUN, dec=1, data_out > 1: data_out decrements by 1 next cycle.
REQ-020 RUN, dec=1, data_out == 1, AUTO_RELOAD=0: data_out = 0, state = DONE, tc = 1 for exactly the following cycle.
REQ-021 RUN, dec=1, data_out == 1, AUTO_RELOAD=1: data_out = reload register, state remains RUN, tc = 1 for the following cycle.
REQ-022 RUN, dec=0: data_out holds, no tc.
REQ-023 RUN, stop=1 (no ld): state = IDLE, data_out holds, no tc, even when dec=1 in the same cycle.
REQ-024 DONE: data_out held at 0; start ignored; dec=1 SHALL set err_underflow and data_out SHALL stay 0 (saturate, no wrap to all-ones).
REQ-025 err_underflow SHALL remain set until ld or rst.
REQ-026 Arithmetic unsigned WIDTH bits; data_out SHALL never wrap from 0 to 2^WIDTH-1.
REQ-027 tc SHALL be 0 in every cycle not immediately following a terminal-count decrement.

Reset
REQ-028 rst asserted: immediately and asynchronously state = IDLE, data_out = 0, reload register = 0, tc = 0, err_underflow = 0; busy = 0, zero = 1.
REQ-029 rst asserted mid-RUN SHALL abort without a tc pulse; first state change after rst deassertion occurs at the next posedge clk.

Verification
REQ-030 WIDTH=3: ld data_in=3, start, dec held high -> data_out 3,2,1,0; tc high one cycle aligned with data_out=0; state DONE; busy low.
REQ-031 AUTO_RELOAD=1: ld 2, start, dec high 6 cycles -> data_out 2,1,2,1,2,1,2; tc pulses 3 times; busy stays high.
REQ-032 After REQ-030 in DONE, dec=1 -> err_underflow=1, data_out stays 0; then ld 5 -> err_underflow=0, data_out=5, IDLE.
REQ-033 ld 7, start, dec 2 cycles, stop+dec same cycle -> data_out=5, IDLE, no tc; start resumes RUN from 5.
REQ-034 ld 0, start -> DONE immediately, tc never asserted, zero=1.
REQ-035 ld 4, start, dec 1 cycle, rst pulsed asynchronously between edges -> data_out=0, busy=0, tc=0 before next posedge.
